led_slot_module: RTL and testbench
==================================

# led_slot_module

Time-slot LED driver for the running-LED (chaser) demo. One instance drives one LED. The instance lights its LED during its own slot of a repeating frame made of NUM_SLOTS equal slots. The legacy led0_module, led1_module and led2_module are this block instantiated with SLOT = 0, 1 and 2. Instances with different SLOT values sit side by side under the chaser top level, share CLK and RSTn, and together produce a one-LED-at-a-time sweep.

## Interface

- SLOT, default 0: index of the slot in which LED_Out is high. Legal range 0 .. NUM_SLOTS-1.
- NUM_SLOTS, default 4: number of slots per frame. Minimum 1.
- T_SLOT, default 50: slot length in CLK cycles. Minimum 1. With the default 2 ms CLK period, 50 cycles gives a 100 ms slot.

- CLK, input, 1: single clock. All state changes on the rising edge.
- RSTn, input, 1: reset, asynchronous, active-high. The port keeps the codebase name RSTn, but a 1 asserts reset.
- LED_Out, input/output: output, 1, registered LED drive; 1 = LED on.

## Operation

- PERIOD = NUM_SLOTS * T_SLOT.
- The frame counter C is an unsigned counter, clog2(PERIOD) bits wide, minimum 1 bit.
- Window W is the cycle range SLOT*T_SLOT <= C <= (SLOT+1)*T_SLOT - 1.
- While RSTn = 1: C = 0 and LED_Out = 0, forced immediately (asynchronously), not at the next edge.
- Each rising CLK edge with RSTn = 0:
  - C <= (C == PERIOD-1) ? 0 : C + 1.
  - LED_Out <= 1 if the pre-edge value of C lies in W, else 0.
- Frame wrap: C goes from PERIOD-1 to 0 with no idle cycle. The counter never takes a value of PERIOD or above.
- Only comparisons against constants are used; no arithmetic overflow is possible.
- Parameter checks at elaboration are fatal errors:
  - SLOT >= NUM_SLOTS
  - T_SLOT < 1
  - NUM_SLOTS < 1
- Across instances sharing CLK and RSTn with distinct SLOT values, at most one LED_Out is high in any cycle.
- When fewer instances than NUM_SLOTS exist (for example SLOT 0..2 of 4), every LED is dark during the unused slots.
- NUM_SLOTS = 1: LED_Out is high continuously from edge 1 after reset release.
- No other inputs; no enable; no handshake.

## Timing

- Output latency is 1 cycle: LED_Out reflects C from the previous cycle.
- Edge numbering: edge n is the n-th rising CLK edge after RSTn falls to 0. C equals n mod PERIOD after edge n.
- LED_Out is high after edges SLOT*T_SLOT + 1 through (SLOT+1)*T_SLOT, then repeats every PERIOD edges.
- Each high pulse is exactly T_SLOT cycles wide and appears once per frame. Duty cycle is 1/NUM_SLOTS.
- Reset asserted mid-frame: LED_Out and C clear immediately.
- Reset release: the sequence restarts from edge 1, as after power-up.
- Reset release coinciding with a CLK edge: that edge is ignored; counting starts at the next edge.
- The output is glitch-free: it is a direct flop output with no combinational path to the port.

## Test plan

- Reset hold: RSTn = 1 for 10 edges, any SLOT -> LED_Out = 0 throughout; C stays 0.
- SLOT = 0, defaults (PERIOD 200) -> LED_Out = 1 after edges 1..50, 0 after edges 51..200, 1 again after edges 201..250.
- SLOT = 1 and SLOT = 2, defaults -> LED_Out high after edges 51..100 and 101..150 respectively, 0 elsewhere. Both pulses are 50 cycles wide.
- Three instances SLOT 0/1/2 in parallel, run 3 frames -> never more than one output high; all outputs low after edges 151..200 of every frame.
- Async reset mid-pulse: SLOT = 1, assert RSTn = 1 between edges 75 and 76, without waiting for a clock edge.
  - LED_Out drops to 0 immediately.
  - After release, LED_Out goes high after new edge 51.
- Corner parameters, NUM_SLOTS = 2, T_SLOT = 1:
  - SLOT = 0 -> LED_Out toggles 1,0,1,0… starting after edge 1.
  - SLOT = 1 -> the complementary pattern.

Source files
------------

// File: rtl/led_slot_if.sv
// LED drive bundle between a slot driver and whatever consumes the LED signal.
interface led_slot_if;
  logic LED_Out;

  modport master (output LED_Out);
  modport slave  (input  LED_Out);
endinterface

// File: rtl/led_slot_module.sv
// One LED of the chaser: lights its LED during its own slot of a repeating
// frame of NUM_SLOTS slots, each T_SLOT clock cycles long.
module led_slot_module #(
  parameter int SLOT      = 0,
  parameter int NUM_SLOTS = 4,
  parameter int T_SLOT    = 50
) (
  input  logic       CLK,
  input  logic       RSTn,
  led_slot_if.master led
);

  localparam int PERIOD = NUM_SLOTS * T_SLOT;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int W_LO   = SLOT * T_SLOT;
  localparam int W_HI   = (SLOT + 1) * T_SLOT - 1;
  localparam logic [CW-1:0] C_LAST = CW'(PERIOD - 1);

  if (NUM_SLOTS < 1) begin : g_bad_num_slots
    $fatal(1, "led_slot_module: NUM_SLOTS must be at least 1");
  end
  if (T_SLOT < 1) begin : g_bad_t_slot
    $fatal(1, "led_slot_module: T_SLOT must be at least 1");
  end
  if (SLOT < 0 || SLOT >= NUM_SLOTS) begin : g_bad_slot
    $fatal(1, "led_slot_module: SLOT must lie in 0 .. NUM_SLOTS-1");
  end

  logic [CW-1:0] c;
  logic          in_win;

  // Signed int compare keeps the SLOT = 0 lower bound from being a constant compare.
  always_comb begin
    in_win = (int'(c) >= W_LO) && (int'(c) <= W_HI);
  end

  // RSTn is active-high despite its name.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      c           <= '0;
      led.LED_Out <= 1'b0;
    end else begin
      c           <= (c == C_LAST) ? '0 : c + 1'b1;
      led.LED_Out <= in_win;
    end
  end

endmodule

// File: tb/tb_led_slot_module.sv
// Directed bench: three default-parameter slots side by side, plus the
// NUM_SLOTS = 2 / T_SLOT = 1 corner pair and a single-slot instance.
module tb_led_slot_module;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  led_slot_if if0 ();
  led_slot_if if1 ();
  led_slot_if if2 ();
  led_slot_if ifa ();
  led_slot_if ifb ();
  led_slot_if ifs ();

  led_slot_module #(.SLOT(0)) u0 (.CLK(clk), .RSTn(rst), .led(if0.master));
  led_slot_module #(.SLOT(1)) u1 (.CLK(clk), .RSTn(rst), .led(if1.master));
  led_slot_module #(.SLOT(2)) u2 (.CLK(clk), .RSTn(rst), .led(if2.master));
  led_slot_module #(.SLOT(0), .NUM_SLOTS(2), .T_SLOT(1)) ua (.CLK(clk), .RSTn(rst), .led(ifa.master));
  led_slot_module #(.SLOT(1), .NUM_SLOTS(2), .T_SLOT(1)) ub (.CLK(clk), .RSTn(rst), .led(ifb.master));
  led_slot_module #(.SLOT(0), .NUM_SLOTS(1), .T_SLOT(3)) us (.CLK(clk), .RSTn(rst), .led(ifs.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // LED state after edge n: high when edge n-1 (mod period) falls in this slot.
  function automatic logic exp_led(input int n, input int slot, input int t, input int ns);
    int k;
    k = (n - 1) % (ns * t);
    return logic'((k / t) == slot);
  endfunction

  task automatic edge_n();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;

    // Reset hold
    for (int i = 0; i < 10; i++) begin
      edge_n();
      chk("hold_led0", 32'(if0.LED_Out), 0);
      chk("hold_led1", 32'(if1.LED_Out), 0);
      chk("hold_ledb", 32'(ifb.LED_Out), 0);
      chk("hold_c0", 32'(u0.c), 0);
    end

    // Three full frames
    release_rst();
    for (int n = 1; n <= 600; n++) begin
      edge_n();
      chk("slot0", 32'(if0.LED_Out), 32'(exp_led(n, 0, 50, 4)));
      chk("slot1", 32'(if1.LED_Out), 32'(exp_led(n, 1, 50, 4)));
      chk("slot2", 32'(if2.LED_Out), 32'(exp_led(n, 2, 50, 4)));
      chk("c0", 32'(u0.c), 32'(n % 200));
      chk("corner_s0", 32'(ifa.LED_Out), 32'(n % 2));
      chk("corner_s1", 32'(ifb.LED_Out), 32'((n + 1) % 2));
      chk("single", 32'(ifs.LED_Out), 1);
      ones = int'(if0.LED_Out) + int'(if1.LED_Out) + int'(if2.LED_Out);
      chk("one_hot", 32'(ones > 1), 0);
      if ((n - 1) % 200 >= 150)
        chk("unused_slot", 32'(ones), 0);
    end

    // Async reset in the middle of slot 1's pulse
    rst = 1'b1;
    #1;
    release_rst();
    for (int n = 1; n <= 75; n++) edge_n();
    chk("pre_abort_led1", 32'(if1.LED_Out), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_led1", 32'(if1.LED_Out), 0);
    chk("abort_c0", 32'(u0.c), 0);
    edge_n();
    edge_n();
    chk("abort_hold_led1", 32'(if1.LED_Out), 0);
    release_rst();
    for (int n = 1; n <= 110; n++) begin
      edge_n();
      chk("restart_slot1", 32'(if1.LED_Out), 32'(exp_led(n, 1, 50, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
